// File: rtl/fpga_ram_pkg.sv
// +--------------------------------------------------------------------------+
// | fpga_ram_pkg : shared widths, slot-length default and packer state type  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package fpga_ram_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int ADDR_W_DEFAULT = 8;
    localparam int FH_NUM_DEFAULT = 904;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PACK  = 3'd1,
        FLUSH = 3'd2,
        CSUM  = 3'd3,
        DONE  = 3'd4
    } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/rx_bit_shifter.sv
// +--------------------------------------------------------------------------+
// | rx_bit_shifter : MSB-first serial-to-parallel shifter with word strobe   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module rx_bit_shifter #(
    parameter int DATA_W = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        shift_en,
    input  logic                        bit_data,
    output logic [DATA_W-1:0]           sreg,
    output logic [$clog2(DATA_W)-1:0]   bit_cnt,
    output logic [DATA_W-1:0]           word,
    output logic                        word_ready
);

    localparam int CNT_W = $clog2(DATA_W);

    // word is the register contents as they will be after this shift
    assign word       = {sreg[DATA_W-2:0], bit_data};
    assign word_ready = shift_en && (bit_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            sreg    <= word;
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/rx_data_packer.sv
// +--------------------------------------------------------------------------+
// | rx_data_packer : packs one receive slot of bits into 32-bit RAM writes   |
// | Option RX_CHECKSUM_EN appends an XOR checksum word to every slot.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module rx_data_packer
    import fpga_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int LEN_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              slot_start,
    input  logic [LEN_W-1:0]  slot_len,
    input  logic              bit_valid,
    input  logic              bit_data,
    output logic [ADDR_W-1:0] rx_data_ram_addr,
    output logic [DATA_W-1:0] rx_data_ram_data,
    output logic              rx_data_ram_wr,
    output logic [ADDR_W:0]   word_cnt,
    output logic              slot_done,
    output logic              overflow,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int SH_W  = CNT_W + 1;
`ifdef RX_CHECKSUM_EN
    localparam rx_state_e POST_DATA = CSUM;
`else
    localparam rx_state_e POST_DATA = DONE;
`endif

    rx_state_e          state;
    rx_state_e          state_nxt;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   bit_total;
    logic [ADDR_W-1:0]  addr;
    logic               shift_en;
    logic               word_ready;
    logic [DATA_W-1:0]  sreg;
    logic [DATA_W-1:0]  word;
    logic [CNT_W-1:0]   bit_cnt;
    logic               wr_req;
    logic [DATA_W-1:0]  wr_word;
`ifdef RX_CHECKSUM_EN
    logic [DATA_W-1:0]  csum;
`endif

    rx_bit_shifter #(
        .DATA_W     (DATA_W)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .clear      (slot_start),
        .shift_en   (shift_en),
        .bit_data   (bit_data),
        .sreg       (sreg),
        .bit_cnt    (bit_cnt),
        .word       (word),
        .word_ready (word_ready)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // slot_start restarts from any state and wins over a coincident bit
    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        if (slot_start) begin
            state_nxt = (slot_len == '0) ? POST_DATA : PACK;
        end else begin
            case (state)
                IDLE:  state_nxt = IDLE;
                PACK: begin
                    if (bit_valid) begin
                        shift_en = 1'b1;
                        if (bit_total == len_q - LEN_W'(1)) begin
                            state_nxt = (bit_cnt == CNT_W'(DATA_W - 1)) ? POST_DATA : FLUSH;
                        end
                    end
                end
                FLUSH: state_nxt = POST_DATA;
                CSUM:  state_nxt = DONE;
                DONE:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        wr_req  = word_ready;
        wr_word = word;
        if (!word_ready && !slot_start) begin
            if (state == FLUSH) begin
                wr_req  = 1'b1;
                wr_word = sreg << (SH_W'(DATA_W) - SH_W'(bit_cnt));
            end
`ifdef RX_CHECKSUM_EN
            else if (state == CSUM) begin
                wr_req  = 1'b1;
                wr_word = csum;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data_ram_addr <= '0;
            rx_data_ram_data <= '0;
            rx_data_ram_wr   <= 1'b0;
            word_cnt         <= '0;
            slot_done        <= 1'b0;
            overflow         <= 1'b0;
            len_q            <= '0;
            bit_total        <= '0;
            addr             <= '0;
`ifdef RX_CHECKSUM_EN
            csum             <= '0;
`endif
        end else begin
            rx_data_ram_wr <= wr_req;
            slot_done      <= (state == DONE) && !slot_start;
            if (wr_req) begin
                rx_data_ram_addr <= addr;
                rx_data_ram_data <= wr_word;
                addr             <= addr + ADDR_W'(1);
                word_cnt         <= word_cnt + (ADDR_W + 1)'(1);
                if (addr == '1) begin
                    overflow <= 1'b1;
                end
`ifdef RX_CHECKSUM_EN
                csum <= csum ^ wr_word;
`endif
            end
            if (slot_start) begin
                len_q     <= slot_len;
                bit_total <= '0;
                addr      <= '0;
                word_cnt  <= '0;
                overflow  <= 1'b0;
`ifdef RX_CHECKSUM_EN
                csum      <= '0;
`endif
            end else if (shift_en) begin
                bit_total <= bit_total + LEN_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rx_data_packer.sv
// +--------------------------------------------------------------------------+
// | tb_rx_data_packer : randomized self-checking bench for rx_data_packer    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_rx_data_packer;
    import fpga_ram_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 32;
`ifdef RX_CHECKSUM_EN
    localparam int CSUM_WORDS = 1;
`else
    localparam int CSUM_WORDS = 0;
`endif
    localparam logic [31:0] PAT = 32'h7CD215D8;

    logic              clk;
    logic              rst;
    logic              slot_start;
    logic [LEN_W-1:0]  slot_len;
    logic              bit_valid;
    logic              bit_data;
    logic [ADDR_W-1:0] rx_data_ram_addr;
    logic [DATA_W-1:0] rx_data_ram_data;
    logic              rx_data_ram_wr;
    logic [ADDR_W:0]   word_cnt;
    logic              slot_done;
    logic              overflow;
    logic              busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int start_cyc;

    logic [ADDR_W-1:0] wa[$];
    logic [DATA_W-1:0] wd[$];
    int                wc[$];
    bit                exp_bits[$];
    int                bit_cyc[$];

    rx_data_packer #(
        .DATA_W           (DATA_W),
        .ADDR_W           (ADDR_W),
        .LEN_W            (LEN_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .slot_start       (slot_start),
        .slot_len         (slot_len),
        .bit_valid        (bit_valid),
        .bit_data         (bit_data),
        .rx_data_ram_addr (rx_data_ram_addr),
        .rx_data_ram_data (rx_data_ram_data),
        .rx_data_ram_wr   (rx_data_ram_wr),
        .word_cnt         (word_cnt),
        .slot_done        (slot_done),
        .overflow         (overflow),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_data_ram_wr === 1'b1) begin
            wa.push_back(rx_data_ram_addr);
            wd.push_back(rx_data_ram_data);
            wc.push_back(cyc);
        end
        if (slot_done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic start_slot(input int len, input bit hold_valid);
        wa.delete(); wd.delete(); wc.delete();
        exp_bits.delete(); bit_cyc.delete();
        done_cnt   = 0;
        done_cyc   = -1;
        slot_start = 1'b1;
        slot_len   = len;
        bit_valid  = hold_valid;
        bit_data   = 1'b1;
        start_cyc  = cyc;
        @(negedge clk);
        slot_start = 1'b0;
        bit_valid  = 1'b0;
        slot_len   = $urandom;
    endtask

    task automatic send_bits(input int n, input bit gaps, input bit use_pat, input logic [31:0] pat);
        int g;
        bit b;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    bit_valid = 1'b0;
                    bit_data  = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
            end
            b = use_pat ? pat[31 - (i % 32)] : 1'($urandom_range(0, 1));
            bit_valid = 1'b1;
            bit_data  = b;
            exp_bits.push_back(b);
            bit_cyc.push_back(cyc);
            @(negedge clk);
        end
        bit_valid = 1'b0;
    endtask

    task automatic send_junk(input int k);
        repeat (k) begin
            bit_valid = 1'b1;
            bit_data  = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bit_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            failures++;
            $display("FAIL %s slot_done: not seen within %0d cycles, required a pulse", name, budget);
        end
        repeat (3) @(negedge clk);
    endtask

    // Expected RAM image: bits laid MSB-first into words, last word zero-padded
    task automatic check_slot(input string name);
        logic [31:0] exp_w[$];
        logic [31:0] word_v;
        logic [31:0] x;
        int nb, nw, idx, n;
        nb = exp_bits.size();
        nw = (nb + 31) / 32;
        x  = '0;
        for (int w = 0; w < nw; w++) begin
            word_v = '0;
            for (int b = 0; b < 32; b++) begin
                idx = w * 32 + b;
                if (idx < nb) word_v[31 - b] = exp_bits[idx];
            end
            exp_w.push_back(word_v);
            x = x ^ word_v;
        end
        if (CSUM_WORDS == 1) exp_w.push_back(x);

        checks++;
        if (wd.size() != exp_w.size()) begin
            failures++;
            $display("FAIL %s write_count: got %0d, required %0d", name, wd.size(), exp_w.size());
        end
        n = (wd.size() < exp_w.size()) ? wd.size() : exp_w.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (wa[i] !== ADDR_W'(i % 256) || wd[i] !== exp_w[i]) begin
                failures++;
                $display("FAIL %s word%0d: got addr=%0d data=%h, required addr=%0d data=%h",
                         name, i, wa[i], wd[i], i % 256, exp_w[i]);
            end
        end
        checks++;
        if (word_cnt !== (ADDR_W + 1)'(exp_w.size())) begin
            failures++;
            $display("FAIL %s word_cnt: got %0d, required %0d", name, word_cnt, exp_w.size());
        end
        checks++;
        if (overflow !== (exp_w.size() > 256)) begin
            failures++;
            $display("FAIL %s overflow: got %b, required %b", name, overflow, exp_w.size() > 256);
        end
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s done_pulses/busy: got %0d/%b, required 1/0", name, done_cnt, busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_data_ram_wr, rx_data_ram_addr, rx_data_ram_data, word_cnt, slot_done, overflow, busy} !== '0) begin
            failures++;
            $display("FAIL reset_values: got wr=%b addr=%h data=%h cnt=%0d done=%b ovf=%b busy=%b, required all 0",
                     rx_data_ram_wr, rx_data_ram_addr, rx_data_ram_data, word_cnt, slot_done, overflow, busy);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_pattern64();
        start_slot(64, 1'b0);
        send_bits(64, 1'b0, 1'b1, PAT);
        send_junk(3);
        wait_done("pattern64", 20);
        check_slot("pattern64");
        checks++;
        if (wc.size() < 1 || wc[0] != bit_cyc[31] + 1) begin
            failures++;
            $display("FAIL pattern64 wr_latency: got first write at cycle %0d, required %0d",
                     (wc.size() > 0) ? wc[0] : -1, bit_cyc[31] + 1);
        end
        checks++;
        if (wc.size() < 1 || done_cyc != wc[wc.size() - 1] + 1) begin
            failures++;
            $display("FAIL pattern64 done_timing: got slot_done at cycle %0d, required one after last write", done_cyc);
        end
    endtask

    task automatic test_slot904();
        start_slot(FH_NUM_DEFAULT, 1'b0);
        send_bits(FH_NUM_DEFAULT, 1'b1, 1'b0, '0);
        send_junk(4);
        wait_done("slot904", 40);
        check_slot("slot904");
    endtask

    task automatic test_zero_len();
        start_slot(0, 1'b0);
        wait_done("zero_len", 20);
        checks++;
        if (done_cyc - start_cyc != 2 + CSUM_WORDS) begin
            failures++;
            $display("FAIL zero_len done_delay: got %0d cycles, required %0d", done_cyc - start_cyc, 2 + CSUM_WORDS);
        end
        check_slot("zero_len");
    endtask

    task automatic test_wrap();
        start_slot(8224, 1'b0);
        send_bits(8224, 1'b0, 1'b0, '0);
        wait_done("wrap", 20);
        check_slot("wrap");
    endtask

    task automatic test_abort();
        start_slot(FH_NUM_DEFAULT, 1'b0);
        send_bits(40, 1'b1, 1'b0, '0);
        checks++;
        if (busy !== 1'b1 || word_cnt !== 9'd1) begin
            failures++;
            $display("FAIL abort pre_state: got busy=%b cnt=%0d, required busy=1 cnt=1", busy, word_cnt);
        end
        start_slot(64, 1'b1);
        send_bits(64, 1'b1, 1'b0, '0);
        send_junk(2);
        wait_done("abort", 20);
        check_slot("abort");
    endtask

    task automatic test_async_reset();
        start_slot(FH_NUM_DEFAULT, 1'b0);
        send_bits(40, 1'b0, 1'b1, PAT);
        checks++;
        if (busy !== 1'b1 || rx_data_ram_data !== PAT) begin
            failures++;
            $display("FAIL async_reset pre_state: got busy=%b data=%h, required busy=1 data=%h", busy, rx_data_ram_data, PAT);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({rx_data_ram_wr, rx_data_ram_addr, rx_data_ram_data, word_cnt, slot_done, overflow, busy} !== '0) begin
            failures++;
            $display("FAIL async_reset outputs: got addr=%h data=%h cnt=%0d busy=%b, required all 0",
                     rx_data_ram_addr, rx_data_ram_data, word_cnt, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_slot(64, 1'b0);
        send_bits(64, 1'b1, 1'b1, PAT);
        wait_done("after_reset", 20);
        check_slot("after_reset");
    endtask

    initial begin
        rst        = 1'b0;
        slot_start = 1'b0;
        slot_len   = '0;
        bit_valid  = 1'b0;
        bit_data   = 1'b0;
        test_reset();
        test_pattern64();
        test_slot904();
        test_zero_len();
        test_wrap();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
